// File: rtl/mvm_weight_loader_if.sv
// mvm_weight_loader_if
// Groups the three handshake channels of the weight loader into one bundle:
//   - command channel: cmd_valid/cmd_ready plus destination, base address,
//     words per RF, first RF index and RF count
//   - word source:     s_valid/s_ready/s_data (32-bit weight words)
//   - AXIS master:     axis_m_* flit stream towards the MVM tile NoC port
//   - status:          busy (command in progress), done (completion pulse)
// Modports:
//   master - the loader's view (drives ready/flit/status signals)
//   slave  - the environment's view (drives commands, words and tready)
interface mvm_weight_loader_if #(
  parameter int TDATAW = 107,
  parameter int DESTW  = 12,
  parameter int IDW    = 5,
  parameter int USERW  = 75,
  parameter int NUM_RF = 64,
  parameter int ADDRW  = 9,
  parameter int LENW   = 10
);
  localparam int RFW = $clog2(NUM_RF);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DESTW-1:0]  cmd_dest;
  logic [ADDRW-1:0]  cmd_base_addr;
  logic [LENW-1:0]   cmd_len;
  logic [RFW-1:0]    cmd_rf_first;
  logic [RFW:0]      cmd_rf_count;

  logic              s_valid;
  logic              s_ready;
  logic [31:0]       s_data;

  logic              axis_m_tvalid;
  logic              axis_m_tready;
  logic [TDATAW-1:0] axis_m_tdata;
  logic [IDW-1:0]    axis_m_tid;
  logic [DESTW-1:0]  axis_m_tdest;
  logic [USERW-1:0]  axis_m_tuser;
  logic              axis_m_tlast;

  logic              busy;
  logic              done;

  modport master (
    input  cmd_valid, cmd_dest, cmd_base_addr, cmd_len, cmd_rf_first, cmd_rf_count,
    output cmd_ready,
    input  s_valid, s_data,
    output s_ready,
    output axis_m_tvalid, axis_m_tdata, axis_m_tid, axis_m_tdest, axis_m_tuser, axis_m_tlast,
    input  axis_m_tready,
    output busy, done
  );

  modport slave (
    output cmd_valid, cmd_dest, cmd_base_addr, cmd_len, cmd_rf_first, cmd_rf_count,
    input  cmd_ready,
    output s_valid, s_data,
    input  s_ready,
    input  axis_m_tvalid, axis_m_tdata, axis_m_tid, axis_m_tdest, axis_m_tuser, axis_m_tlast,
    output axis_m_tready,
    input  busy, done
  );
endinterface

// File: rtl/mvm_weight_loader.sv
// mvm_weight_loader
// Streams register-file weight words into the MVM tile as single-flit AXIS
// packets. One command names a destination, a base RF address, a word count
// per RF and a range of register files; the loader then pulls one 32-bit
// word per flit from the word source, walking RF-outer / address-inner.
// Each flit carries: word in [31:0], RF address in [32 +: ADDRW], and a
// one-hot RF select at bit RF_SEL_LSB + rf. Address and RF index wrap.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset (abandons any command in flight)
//   bus  - mvm_weight_loader_if.master: command, word source, AXIS master,
//          busy/done status
module mvm_weight_loader #(
  parameter int TDATAW     = 107,
  parameter int DESTW      = 12,
  parameter int IDW        = 5,
  parameter int USERW      = 75,
  parameter int NUM_RF     = 64,
  parameter int ADDRW      = 9,
  parameter int LENW       = 10,
  parameter int RF_SEL_LSB = 41
) (
  input logic              clk,
  input logic              rst,
  mvm_weight_loader_if.master bus
);
  localparam int RFW = $clog2(NUM_RF);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } state_t;

  state_t state, state_next;

  // Latched command and walking position of the flit currently held.
  logic [DESTW-1:0]  dest_q;
  logic [ADDRW-1:0]  base_q;
  logic [LENW-1:0]   len_q;
  logic [RFW:0]      count_q;
  logic [ADDRW-1:0]  addr_q;
  logic [RFW-1:0]    rf_q;
  logic [LENW-1:0]   word_q;
  logic [RFW:0]      rf_done_q;
  logic [TDATAW-1:0] flit_q;

  // Position of the flit after the current one.
  logic              word_last;
  logic              rf_last;
  logic              last_flit;
  logic [ADDRW-1:0]  addr_adv;
  logic [RFW-1:0]    rf_adv;
  logic [LENW-1:0]   word_adv;
  logic [RFW:0]      rf_done_adv;

  logic cmd_ready, s_ready, tvalid, busy, done;

  function automatic logic [TDATAW-1:0] build_flit(
    input logic [31:0]      word,
    input logic [ADDRW-1:0] addr,
    input logic [RFW-1:0]   rf
  );
    logic [TDATAW-1:0] f;
    f = '0;
    f[31:0] = word;
    f[32 +: ADDRW] = addr;
    f = f | (TDATAW'(1) << (RF_SEL_LSB + int'(rf)));
    return f;
  endfunction

  // Counters are only meaningful in FETCH/SEND, where len_q and count_q are
  // nonzero, so the minus-one compares never see an underflow that matters.
  always_comb begin
    word_last   = (word_q == len_q - LENW'(1));
    rf_last     = (rf_done_q == count_q - (RFW+1)'(1));
    last_flit   = word_last && rf_last;
    word_adv    = word_last ? '0 : word_q + LENW'(1);
    addr_adv    = word_last ? base_q : addr_q + ADDRW'(1);
    rf_done_adv = word_last ? rf_done_q + (RFW+1)'(1) : rf_done_q;
    if (!word_last)
      rf_adv = rf_q;
    else if (rf_q == RFW'(NUM_RF - 1))
      rf_adv = '0;
    else
      rf_adv = rf_q + RFW'(1);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next state and handshake outputs. In SEND the word source is offered a
  // slot in the same cycle as a non-final flit handshake, so that a
  // continuous source sustains one flit per cycle.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    s_ready    = 1'b0;
    tvalid     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          if (bus.cmd_len == '0 || bus.cmd_rf_count == '0)
            state_next = DONE;
          else
            state_next = FETCH;
        end
      end
      FETCH: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        if (bus.s_valid)
          state_next = SEND;
      end
      SEND: begin
        busy    = 1'b1;
        tvalid  = 1'b1;
        s_ready = bus.axis_m_tready && !last_flit;
        if (bus.axis_m_tready) begin
          if (last_flit)
            state_next = DONE;
          else if (bus.s_valid)
            state_next = SEND;
          else
            state_next = FETCH;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command latch, walking counters and flit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest_q    <= '0;
      base_q    <= '0;
      len_q     <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      rf_q      <= '0;
      word_q    <= '0;
      rf_done_q <= '0;
      flit_q    <= '0;
    end else begin
      if (state == IDLE && bus.cmd_valid) begin
        dest_q    <= bus.cmd_dest;
        base_q    <= bus.cmd_base_addr;
        len_q     <= bus.cmd_len;
        count_q   <= bus.cmd_rf_count;
        addr_q    <= bus.cmd_base_addr;
        rf_q      <= bus.cmd_rf_first;
        word_q    <= '0;
        rf_done_q <= '0;
      end
      if (state == FETCH && bus.s_valid)
        flit_q <= build_flit(bus.s_data, addr_q, rf_q);
      if (state == SEND && bus.axis_m_tready && !last_flit) begin
        word_q    <= word_adv;
        addr_q    <= addr_adv;
        rf_q      <= rf_adv;
        rf_done_q <= rf_done_adv;
        if (bus.s_valid)
          flit_q <= build_flit(bus.s_data, addr_adv, rf_adv);
      end
    end
  end

  assign bus.cmd_ready     = cmd_ready;
  assign bus.s_ready       = s_ready;
  assign bus.axis_m_tvalid = tvalid;
  // Data is masked while idle so stale flits never appear on the bus.
  assign bus.axis_m_tdata  = tvalid ? flit_q : '0;
  assign bus.axis_m_tid    = IDW'(0);
  assign bus.axis_m_tuser  = USERW'(0);
  assign bus.axis_m_tdest  = dest_q;
  assign bus.axis_m_tlast  = tvalid;
  assign bus.busy          = busy;
  assign bus.done          = done;

endmodule

// File: tb/tb_mvm_weight_loader.sv
// tb_mvm_weight_loader
// Self-checking bench for mvm_weight_loader. A table of commands (with the
// expected flit count) is run through one driver task that randomizes the
// word source and NoC ready, and compares every flit against a reference
// list built from the command with plain loops. Hand-written sequences
// cover reset in the middle of a command.
module tb_mvm_weight_loader;
  localparam int TDATAW     = 107;
  localparam int DESTW      = 12;
  localparam int IDW        = 5;
  localparam int USERW      = 75;
  localparam int NUM_RF     = 64;
  localparam int ADDRW      = 9;
  localparam int LENW       = 10;
  localparam int RF_SEL_LSB = 41;
  localparam int RFW        = $clog2(NUM_RF);
  localparam int BUDGET     = 3000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mvm_weight_loader_if #(
    .TDATAW(TDATAW), .DESTW(DESTW), .IDW(IDW), .USERW(USERW),
    .NUM_RF(NUM_RF), .ADDRW(ADDRW), .LENW(LENW)
  ) bus ();

  mvm_weight_loader #(
    .TDATAW(TDATAW), .DESTW(DESTW), .IDW(IDW), .USERW(USERW),
    .NUM_RF(NUM_RF), .ADDRW(ADDRW), .LENW(LENW), .RF_SEL_LSB(RF_SEL_LSB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  typedef struct {
    logic [DESTW-1:0] dest;
    logic [ADDRW-1:0] base;
    logic [LENW-1:0]  len;
    logic [RFW-1:0]   first;
    logic [RFW:0]     count;
    int               sv_pct;
    int               tr_pct;
    int               stall;
    bit               poke;
    int               exp_flits;
  } vec_t;

  vec_t vecs[8];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check_output(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference flit: word, address field and one-hot RF select.
  function automatic logic [TDATAW-1:0] exp_flit(input logic [31:0] w,
                                                 input int addr, input int rf);
    logic [TDATAW-1:0] e;
    e = '0;
    e[31:0] = w;
    e[32 +: ADDRW] = ADDRW'(addr);
    e = e | (TDATAW'(1) << (RF_SEL_LSB + rf));
    return e;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_cmd_ready"}, 128'(bus.cmd_ready), 128'(1));
    check_output({tag, "_s_ready"}, 128'(bus.s_ready), 128'(0));
    check_output({tag, "_tvalid"}, 128'(bus.axis_m_tvalid), 128'(0));
    check_output({tag, "_tdata"}, 128'(bus.axis_m_tdata), 128'(0));
    check_output({tag, "_tdest"}, 128'(bus.axis_m_tdest), 128'(0));
    check_output({tag, "_tlast"}, 128'(bus.axis_m_tlast), 128'(0));
    check_output({tag, "_busy"}, 128'(bus.busy), 128'(0));
    check_output({tag, "_done"}, 128'(bus.done), 128'(0));
  endtask

  // Issues one command and drives it to completion (or to abort_at flits).
  task automatic apply_stimulus(input vec_t v, input int abort_at, output int flits);
    int addr_list[$];
    int rf_list[$];
    logic [31:0] words[$];
    int total, idx, first_hs, last_hs, stall_left;
    bit exp_done, exp_done_next, prev_stall, finished;
    logic [TDATAW-1:0] prev_data;
    logic tv, tr, sv, sr;

    total = int'(v.len) * int'(v.count);
    for (int r = 0; r < int'(v.count); r++)
      for (int a = 0; a < int'(v.len); a++) begin
        rf_list.push_back((int'(v.first) + r) % NUM_RF);
        addr_list.push_back((int'(v.base) + a) % (1 << ADDRW));
      end

    @(negedge clk);
    bus.cmd_valid     = 1'b1;
    bus.cmd_dest      = v.dest;
    bus.cmd_base_addr = v.base;
    bus.cmd_len       = v.len;
    bus.cmd_rf_first  = v.first;
    bus.cmd_rf_count  = v.count;
    bus.s_valid       = 1'b0;
    bus.axis_m_tready = 1'b0;
    #1;
    check_output("cmd_ready_idle", 128'(bus.cmd_ready), 128'(1));
    @(negedge clk);

    idx = 0; first_hs = -1; last_hs = -1; stall_left = v.stall;
    exp_done = (total == 0); prev_stall = 1'b0; finished = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      if (cyc > 0) @(negedge clk);
      bus.s_valid       = (int'($urandom_range(99)) < v.sv_pct);
      bus.s_data        = $urandom;
      bus.axis_m_tready = (int'($urandom_range(99)) < v.tr_pct);
      if (stall_left > 0 && bus.axis_m_tvalid) begin
        bus.axis_m_tready = 1'b0;
        stall_left--;
      end
      bus.cmd_valid = v.poke ? 1'($urandom_range(1)) : 1'b0;
      if (v.poke) begin
        bus.cmd_dest     = DESTW'($urandom);
        bus.cmd_len      = LENW'($urandom_range(1, 4));
        bus.cmd_rf_count = (RFW+1)'($urandom_range(1, 4));
      end
      #1;
      tv = bus.axis_m_tvalid; tr = bus.axis_m_tready;
      sv = bus.s_valid;       sr = bus.s_ready;
      check_output("cmd_ready_busy", 128'(bus.cmd_ready), 128'(0));
      check_output("done_timing", 128'(bus.done), 128'(exp_done));
      check_output("busy_level", 128'(bus.busy), 128'(!exp_done));
      if (prev_stall) begin
        check_output("tvalid_held", 128'(tv), 128'(1));
        check_output("tdata_held", 128'(bus.axis_m_tdata), 128'(prev_data));
      end
      if (tv && !tr) check_output("s_ready_backpressure", 128'(sr), 128'(0));
      if (words.size() >= total) check_output("s_ready_no_words_left", 128'(sr), 128'(0));
      if (sv && sr) words.push_back(bus.s_data);
      exp_done_next = 1'b0;
      if (tv && tr) begin
        if (idx < total && idx < words.size()) begin
          check_output("flit_tdata", 128'(bus.axis_m_tdata),
                       128'(exp_flit(words[idx], addr_list[idx], rf_list[idx])));
          check_output("flit_tdest", 128'(bus.axis_m_tdest), 128'(v.dest));
          check_output("flit_tlast", 128'(bus.axis_m_tlast), 128'(1));
          check_output("flit_tid_tuser", 128'({bus.axis_m_tid, bus.axis_m_tuser}), 128'(0));
        end else begin
          check_output("flit_unexpected", 128'(idx), 128'(total));
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        idx++;
        exp_done_next = (idx == total);
      end
      prev_stall = tv && !tr;
      prev_data  = bus.axis_m_tdata;
      if (abort_at >= 0 && idx == abort_at) begin
        flits = idx;
        return;
      end
      if (exp_done) begin
        finished = 1'b1;
        break;
      end
      exp_done = exp_done_next;
    end
    flits = idx;

    if (!finished) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL timeout: got %0d flits expected %0d within %0d cycles",
               idx, total, BUDGET);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end

    if (v.sv_pct == 100 && v.tr_pct == 100 && v.stall == 0 && total > 0)
      check_output("throughput_span", 128'(last_hs - first_hs), 128'(total - 1));

    @(negedge clk);
    bus.cmd_valid     = 1'b0;
    bus.s_valid       = 1'b0;
    bus.axis_m_tready = 1'b0;
    #1;
    check_output("cmd_ready_after", 128'(bus.cmd_ready), 128'(1));
    check_output("busy_after", 128'(bus.busy), 128'(0));
    check_output("tvalid_after", 128'(bus.axis_m_tvalid), 128'(0));
  endtask

  initial begin
    int flits;
    vec_t rv;

    vecs[0] = '{12'h002, 9'h1FE, 10'd3,  6'd0,  7'd1, 100, 100, 0, 1'b0, 3};
    vecs[1] = '{12'h0AB, 9'h000, 10'd0,  6'd0,  7'd4, 100, 100, 0, 1'b0, 0};
    vecs[2] = '{12'h155, 9'h010, 10'd5,  6'd7,  7'd0, 100, 100, 0, 1'b0, 0};
    vecs[3] = '{12'h011, 9'h001, 10'd2,  6'd0,  7'd1, 100, 100, 5, 1'b0, 2};
    vecs[4] = '{12'h022, 9'h000, 10'd2,  6'd5,  7'd2, 100, 100, 0, 1'b0, 4};
    vecs[5] = '{12'h033, 9'h000, 10'd1,  6'd63, 7'd2, 100, 100, 0, 1'b1, 2};
    vecs[6] = '{12'h7FF, 9'h1F0, 10'd32, 6'd10, 7'd3, 60,  50,  0, 1'b0, 96};
    vecs[7] = '{12'h3C3, 9'h100, 10'd7,  6'd62, 7'd4, 40,  70,  0, 1'b1, 28};

    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_dest = '0; bus.cmd_base_addr = '0;
    bus.cmd_len = '0; bus.cmd_rf_first = '0; bus.cmd_rf_count = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.axis_m_tready = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i], -1, flits);
      check_output($sformatf("flit_count_vec%0d", i), 128'(flits), 128'(vecs[i].exp_flits));
    end

    // Reset after two of eight flits, then a fresh single-word command.
    rv = '{12'h0F0, 9'h020, 10'd8, 6'd3, 7'd1, 100, 100, 0, 1'b0, 8};
    apply_stimulus(rv, 2, flits);
    check_output("abort_flits", 128'(flits), 128'(2));
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    bus.s_valid = 1'b0;
    bus.axis_m_tready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_output("post_reset_tvalid", 128'(bus.axis_m_tvalid), 128'(0));
    rv = '{12'h00F, 9'h0AA, 10'd1, 6'd9, 7'd1, 100, 100, 0, 1'b0, 1};
    apply_stimulus(rv, -1, flits);
    check_output("post_reset_flits", 128'(flits), 128'(1));

    // A few fully random commands.
    for (int i = 0; i < 4; i++) begin
      rv.dest   = DESTW'($urandom);
      rv.base   = ADDRW'($urandom);
      rv.len    = LENW'($urandom_range(0, 6));
      rv.first  = RFW'($urandom);
      rv.count  = (RFW+1)'($urandom_range(0, 4));
      rv.sv_pct = int'($urandom_range(30, 100));
      rv.tr_pct = int'($urandom_range(30, 100));
      rv.stall  = 0;
      rv.poke   = 1'($urandom_range(1));
      rv.exp_flits = int'(rv.len) * int'(rv.count);
      apply_stimulus(rv, -1, flits);
      check_output($sformatf("flit_count_rand%0d", i), 128'(flits), 128'(rv.exp_flits));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
